// File: rtl/tdc_pkg.sv
// Shared field layout for TDC readings and phase-average results.
// Output width grows by the min/max fields when TDC_PHASE_AVG_MINMAX_EN is defined.
package tdc_pkg;

  // Input word: {t12_valid, t2, t1, t0}, each counter CW bits wide.
  localparam int T0_LSB = 0;

  function automatic int t1_lsb(input int cw);
    return cw;
  endfunction

  function automatic int t2_lsb(input int cw);
    return 2 * cw;
  endfunction

  function automatic int valid_bit(input int cw);
    return 3 * cw;
  endfunction

  function automatic int acc_width(input int cw, input int log2_avg);
    return cw + 1 + log2_avg;
  endfunction

  // Result word: {[max, min,] n_valid, acc}.
  localparam int ACC_LSB = 0;

  function automatic int n_valid_lsb(input int acc_w);
    return acc_w;
  endfunction

  function automatic int min_lsb(input int acc_w, input int log2_avg);
    return acc_w + log2_avg + 1;
  endfunction

  function automatic int max_lsb(input int acc_w, input int cw, input int log2_avg);
    return acc_w + log2_avg + 1 + cw + 1;
  endfunction

  function automatic int out_width(input int acc_w, input int cw, input int log2_avg);
    int w;
    w = acc_w + log2_avg + 1;
`ifdef TDC_PHASE_AVG_MINMAX_EN
    w = w + 2 * (cw + 1);
`else
    w = w + 0 * cw;
`endif
    return w;
  endfunction

endpackage

// File: rtl/tdc_phase_wrap.sv
// Stage A: checks a TDC reading and wraps its first edge t1 into a signed
// phase around the gate period P = t0+1; one register stage with valid/ready.
module tdc_phase_wrap
  import tdc_pkg::*;
#(
  parameter int CW       = 32,
  parameter int IN_WIDTH = 1 + 3 * CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  tdata,
  input  logic                 tvalid,
  output logic                 tready,
  input  logic                 advance,
  output logic                 a_valid,
  output logic                 a_ok,
  output logic signed [CW:0]   a_phase
);

  localparam int VB  = valid_bit(CW);
  localparam int T1L = t1_lsb(CW);
  localparam int T2L = t2_lsb(CW);

  logic              v_in;
  logic [CW-1:0]     t0;
  logic [CW-1:0]     t1;
  logic [CW+1:0]     period;
  logic [CW+1:0]     two_t1;
  logic [CW:0]       wrapped;
  logic signed [CW:0] phase_c;
  logic              unused_t2;

  assign v_in      = tdata[VB];
  assign t1        = tdata[T1L +: CW];
  assign t0        = tdata[T0_LSB +: CW];
  assign unused_t2 = ^tdata[T2L +: CW];

  // Compare in CW+2 bits so that 2*t1 and t0+1 never overflow.
  assign period  = {2'b00, t0} + (CW+2)'(1);
  assign two_t1  = {1'b0, t1, 1'b0};
  assign wrapped = {1'b0, t1} - ({1'b0, t0} + (CW+1)'(1));
  assign phase_c = (two_t1 >= period) ? $signed(wrapped) : $signed({1'b0, t1});

  // Valid/ready: a reading transfers on any edge where tvalid && tready;
  // the stage accepts whenever it is empty or its content moves on this edge.
  assign tready = !a_valid || advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_ok    <= 1'b0;
      a_phase <= '0;
    end else if (tready) begin
      a_valid <= tvalid;
      if (tvalid) begin
        a_ok    <= v_in && (t1 <= t0);
        a_phase <= phase_c;
      end
    end
  end

endmodule

// File: rtl/tdc_phase_avg.sv
// Averages wrapped TDC phases over windows of 2^LOG2_AVG readings and emits
// {[max, min,] n_valid, acc} per window. Optional min/max: TDC_PHASE_AVG_MINMAX_EN.
module tdc_phase_avg
  import tdc_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int IN_WIDTH      = 1 + 3 * COUNTER_WIDTH,
  parameter int LOG2_AVG      = 4,
  parameter int ACC_WIDTH     = COUNTER_WIDTH + 1 + LOG2_AVG,
  parameter int OUT_WIDTH     = out_width(ACC_WIDTH, COUNTER_WIDTH, LOG2_AVG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [IN_WIDTH-1:0]   i_s_axis_tdata,
  input  logic                  i_s_axis_tvalid,
  output logic                  o_s_axis_tready,
  output logic [OUT_WIDTH-1:0]  o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready
);

  localparam int CW = COUNTER_WIDTH;
  localparam logic [LOG2_AVG:0] LAST_IDX = (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);

  logic                        a_valid;
  logic                        a_ok;
  logic signed [CW:0]          a_phase;
  logic                        advance;
  logic                        wrap_ready;
  logic                        consume;
  logic                        is_final;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] phase_ext;
  logic [LOG2_AVG:0]           n_valid;
  logic [LOG2_AVG:0]           n_next;
  logic [LOG2_AVG:0]           idx;
  logic                        m_valid;
  logic [OUT_WIDTH-1:0]        m_data;
  logic [OUT_WIDTH-1:0]        result;

  tdc_phase_wrap #(
    .CW       (CW),
    .IN_WIDTH (IN_WIDTH)
  ) u_wrap (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .tdata   (i_s_axis_tdata),
    .tvalid  (i_s_axis_tvalid),
    .tready  (wrap_ready),
    .advance (advance),
    .a_valid (a_valid),
    .a_ok    (a_ok),
    .a_phase (a_phase)
  );

  // Only a window-final reading needs the output register, so only it can stall.
  assign is_final = (idx == LAST_IDX);
  assign advance  = !(is_final && m_valid && !i_m_axis_tready);
  assign consume  = a_valid && advance;

  assign phase_ext = ACC_WIDTH'(a_phase);
  assign acc_next  = a_ok ? (acc + phase_ext) : acc;
  assign n_next    = n_valid + (LOG2_AVG+1)'(a_ok);

`ifdef TDC_PHASE_AVG_MINMAX_EN
  logic signed [CW:0] min_r;
  logic signed [CW:0] max_r;
  logic signed [CW:0] min_next;
  logic signed [CW:0] max_next;

  // The first valid reading of a window seeds both extremes.
  always_comb begin
    min_next = min_r;
    max_next = max_r;
    if (a_ok) begin
      if ((n_valid == '0) || (a_phase < min_r)) min_next = a_phase;
      if ((n_valid == '0) || (a_phase > max_r)) max_next = a_phase;
    end
  end

  assign result = {max_next, min_next, n_next, acc_next};
`else
  assign result = {n_next, acc_next};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      n_valid <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef TDC_PHASE_AVG_MINMAX_EN
      min_r   <= '0;
      max_r   <= '0;
`endif
    end else begin
      if (m_valid && i_m_axis_tready) begin
        m_valid <= 1'b0;
      end
      if (consume) begin
        if (is_final) begin
          m_data  <= result;
          m_valid <= 1'b1;
          acc     <= '0;
          n_valid <= '0;
          idx     <= '0;
`ifdef TDC_PHASE_AVG_MINMAX_EN
          min_r   <= '0;
          max_r   <= '0;
`endif
        end else begin
          acc     <= acc_next;
          n_valid <= n_next;
          idx     <= idx + (LOG2_AVG+1)'(1);
`ifdef TDC_PHASE_AVG_MINMAX_EN
          min_r   <= min_next;
          max_r   <= max_next;
`endif
        end
      end
    end
  end

  assign o_s_axis_tready = i_rst_n && wrap_ready;
  assign o_m_axis_tvalid = m_valid;
  assign o_m_axis_tdata  = m_data;

endmodule

// File: tb/tb_tdc_phase_avg.sv
// Bench for tdc_phase_avg (CW=8, window of 4): directed windows, back-pressure,
// mid-window reset and random traffic scored against a window-level phase model.
module tb_tdc_phase_avg;
  import tdc_pkg::*;

  localparam int CW   = 8;
  localparam int L2   = 2;
  localparam int IW   = 1 + 3 * CW;
  localparam int ACCW = CW + 1 + L2;
  localparam int OW   = out_width(ACCW, CW, L2);
  localparam int WIN  = 1 << L2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;

  tdc_phase_avg #(
    .COUNTER_WIDTH (CW),
    .LOG2_AVG      (L2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tdata  (s_tdata),
    .i_s_axis_tvalid (s_tvalid),
    .o_s_axis_tready (s_tready),
    .o_m_axis_tdata  (m_tdata),
    .o_m_axis_tvalid (m_tvalid),
    .i_m_axis_tready (m_tready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [OW-1:0] exp_q[$];
  int win_ph[$];
  int win_cnt   = 0;
  int n_windows = 0;
  int n_results = 0;

  function automatic int ref_phase(input int t1, input int t0);
    int p;
    p = t0 + 1;
    if (2 * t1 >= p) return t1 - p;
    return t1;
  endfunction

  function automatic logic [OW-1:0] ref_result();
    logic [OW-1:0] r;
    logic [31:0]   s32;
    logic [31:0]   n32;
    int            sum;
`ifdef TDC_PHASE_AVG_MINMAX_EN
    int            mn;
    int            mx;
    logic [31:0]   mn32;
    logic [31:0]   mx32;
    mn = 0;
    mx = 0;
    foreach (win_ph[i]) begin
      if (i == 0 || win_ph[i] < mn) mn = win_ph[i];
      if (i == 0 || win_ph[i] > mx) mx = win_ph[i];
    end
`endif
    r   = '0;
    sum = 0;
    foreach (win_ph[i]) sum += win_ph[i];
    s32 = sum;
    n32 = win_ph.size();
    r[ACCW-1:0]    = s32[ACCW-1:0];
    r[ACCW +: L2+1] = n32[L2:0];
`ifdef TDC_PHASE_AVG_MINMAX_EN
    mn32 = mn;
    mx32 = mx;
    r[ACCW+L2+1 +: CW+1]      = mn32[CW:0];
    r[ACCW+L2+CW+2 +: CW+1]   = mx32[CW:0];
`endif
    return r;
  endfunction

  // ---------------- monitor / scoreboard (negedge sampling) ----------------
  int            cyc = 0;
  int            final_cyc = -100;
  logic          prev_valid = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_final_stalled = 1'b0;
  logic [OW-1:0] prev_data = '0;

  always @(negedge clk) begin
    logic final_now;
    int   t1;
    int   t0;
    cyc++;
    final_now = 1'b0;
    if (!rst_n) begin
      check_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check_eq("rst_m_tdata", 64'(m_tdata), 64'd0);
      check_eq("rst_s_tready", 64'(s_tready), 64'd0);
      win_ph.delete();
      win_cnt            = 0;
      prev_valid         = 1'b0;
      prev_stall         = 1'b0;
      prev_final_stalled = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_tvalid", 64'(m_tvalid), 64'd1);
        check_eq("hold_tdata", 64'(m_tdata), 64'(prev_data));
      end
      if (prev_final_stalled && m_tvalid && !m_tready)
        check_eq("bp_ready_drop", 64'(s_tready), 64'd0);
      if (m_tvalid && !prev_valid)
        check_eq("latency", 64'(cyc - final_cyc), 64'd2);
      if (m_tvalid && m_tready) begin
        n_results++;
        if (exp_q.size() == 0) check_eq("unexpected_result", 64'(m_tdata), 64'd0 - 64'd1);
        else check_eq("result", 64'(m_tdata), 64'(exp_q.pop_front()));
      end
      if (s_tvalid && s_tready) begin
        t1 = int'(s_tdata[2*CW-1:CW]);
        t0 = int'(s_tdata[CW-1:0]);
        if (s_tdata[3*CW] && t1 <= t0) win_ph.push_back(ref_phase(t1, t0));
        win_cnt++;
        if (win_cnt == WIN) begin
          exp_q.push_back(ref_result());
          win_ph.delete();
          win_cnt   = 0;
          n_windows++;
          final_now = 1'b1;
          final_cyc = cyc;
        end
      end
      prev_final_stalled = final_now && m_tvalid && !m_tready;
      prev_stall         = m_tvalid && !m_tready;
      prev_data          = m_tdata;
      prev_valid         = m_tvalid;
    end
  end

  // ---------------- output ready driver ----------------
  int rdy_mode = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // ---------------- input driver tasks ----------------
  task automatic send(input bit v, input int t1, input int t0);
    int            n;
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [CW-1:0] c;
    n = 0;
    a = CW'(t1);
    b = CW'(t0);
    c = CW'($urandom);
    s_tdata  = {v, c, a, b};
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) check_eq("drain_timeout", 64'(n), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // positive phases, then negative phases
    repeat (4) send(1, 10, 99);
    drain();
    repeat (4) send(1, 60, 99);
    // wrap boundaries: -50, +49, 0, and P=1
    send(1, 50, 99);
    send(1, 49, 99);
    send(1, 0, 99);
    send(1, 0, 0);
    // invalid filtering
    send(0, 3, 99);
    send(1, 120, 99);
    send(1, 5, 99);
    send(1, 7, 99);
    // window with no valid reading
    send(0, 10, 99);
    send(1, 200, 100);
    send(0, 0, 0);
    send(1, 255, 254);
    drain();

    // back-pressure spanning a window end
    fork
      begin
        repeat (16) send(1, $urandom_range(0, 99), 99);
      end
      begin
        int n;
        n = 0;
        while (win_cnt != 2 && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (10) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();

    // reset in the middle of a window
    send(1, 1, 99);
    send(1, 1, 99);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    repeat (4) send(1, 1, 99);
    drain();

    // random traffic with random output ready
    rdy_mode = 1;
    repeat (30 * WIN) begin
      int  t0;
      int  t1;
      bit  v;
      v  = ($urandom_range(0, 7) != 0);
      t0 = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) t1 = $urandom_range(0, 255);
      else                          t1 = $urandom_range(0, t0);
      send(v, t1, t0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    idle(1);
    drain();

    check_eq("leftover_expected", 64'(exp_q.size()), 64'd0);
    check_eq("result_count", 64'(n_results), 64'(n_windows));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
